of_stage_pipelined: RTL and testbench

//  Parametrised operand-fetch stage for the SimpleRISC pipeline, sitting between decode (IF/OF) and execute (EX).

---
 rtl/of_stage_pipelined.sv | 177 +++++++++++++++++
 tb/tb_of_stage_pipelined.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/of_stage_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : of_stage_pipelined
// Brief    : SimpleRISC operand-fetch stage with register file, load-use
//            scoreboard, halt latch and OF/EX pipeline register.
//            Optional macro OF_BYPASS_EN: same-cycle writeback bypass.
// Revision : 1.0 - initial release
// ============================================================================
module of_stage_pipelined #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int RA_IDX = NREGS - 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic            is_st,
    input  logic            is_ret,
    input  logic            is_ld,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_immx,
    output logic [XLEN-1:0] out_branch_target,
    output logic [AW-1:0]   out_rd,
    output logic [5:0]      out_opcode,
    output logic            halted
);

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [XLEN-1:0]  rf_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_pc_q, out_pc_d;
    logic [XLEN-1:0]  out_op1_q, out_op1_d;
    logic [XLEN-1:0]  out_op2_q, out_op2_d;
    logic [XLEN-1:0]  out_immx_q, out_immx_d;
    logic [XLEN-1:0]  out_bt_q, out_bt_d;
    logic [AW-1:0]    out_rd_q, out_rd_d;
    logic [5:0]       out_opcode_q, out_opcode_d;

    logic [AW-1:0]    rp1, rp2, rd;
    logic             byp1, byp2;
    logic             hazard, accept;
    logic [XLEN-1:0]  op1, op2, immx, branch_target;

    // Register fields are 5 bits wide; resize to the configured address width.
    always_comb begin
        rp1 = is_ret ? AW'(RA_IDX) : AW'(in_inst[20:16]);
        rp2 = is_st ? AW'(in_inst[25:21]) : AW'(in_inst[15:11]);
        rd  = AW'(in_inst[25:21]);
    end

`ifdef OF_BYPASS_EN
    always_comb begin
        byp1 = wb_en && (wb_addr == rp1);
        byp2 = wb_en && (wb_addr == rp2);
    end
`else
    always_comb begin
        byp1 = 1'b0;
        byp2 = 1'b0;
    end
`endif

    // A bypassed source is being written this cycle, so its busy bit no longer blocks.
    always_comb begin
        op1           = byp1 ? wb_data : rf_q[rp1];
        op2           = byp2 ? wb_data : rf_q[rp2];
        hazard        = (busy_q[rp1] & ~byp1) | (busy_q[rp2] & ~byp2);
        in_ready      = ~flush & ~halted_q & ~hazard & (~out_valid_q | out_ready);
        accept        = in_valid & in_ready;
        immx          = (in_inst[31:30] == 2'b10)
                      ? {{(XLEN-27){1'b0}}, in_inst[26:0]}
                      : {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
        branch_target = in_pc + {{(XLEN-27){in_inst[26]}}, in_inst[26:0]};
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    // Writeback clear is applied first so a same-register load set wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (accept && is_ld) begin
            busy_d[rd] = 1'b1;
        end
        halted_d = halted_q | (accept && (in_inst[31:27] == 5'b11111));
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_op1_d    = out_op1_q;
        out_op2_d    = out_op2_q;
        out_immx_d   = out_immx_q;
        out_bt_d     = out_bt_q;
        out_rd_d     = out_rd_q;
        out_opcode_d = out_opcode_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_pc_d     = in_pc;
            out_op1_d    = op1;
            out_op2_d    = op2;
            out_immx_d   = immx;
            out_bt_d     = branch_target;
            out_rd_d     = rd;
            out_opcode_d = in_inst[31:26];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            busy_q       <= '0;
            halted_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_op1_q    <= '0;
            out_op2_q    <= '0;
            out_immx_q   <= '0;
            out_bt_q     <= '0;
            out_rd_q     <= '0;
            out_opcode_q <= '0;
        end else begin
            rf_q         <= rf_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_op1_q    <= out_op1_d;
            out_op2_q    <= out_op2_d;
            out_immx_q   <= out_immx_d;
            out_bt_q     <= out_bt_d;
            out_rd_q     <= out_rd_d;
            out_opcode_q <= out_opcode_d;
        end
    end

    always_comb begin
        out_valid         = out_valid_q;
        out_pc            = out_pc_q;
        out_op1           = out_op1_q;
        out_op2           = out_op2_q;
        out_immx          = out_immx_q;
        out_branch_target = out_bt_q;
        out_rd            = out_rd_q;
        out_opcode        = out_opcode_q;
        halted            = halted_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_of_stage_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_of_stage_pipelined
// Brief    : Scoreboard bench for of_stage_pipelined (honours OF_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_of_stage_pipelined;

`ifdef OF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, is_st, is_ret, is_ld, flush, wb_en;
    logic        out_valid, out_ready, halted;
    logic [31:0] in_pc, in_inst, wb_data;
    logic [4:0]  wb_addr, out_rd;
    logic [31:0] out_pc, out_op1, out_op2, out_immx, out_branch_target;
    logic [5:0]  out_opcode;

    of_stage_pipelined dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .is_st(is_st), .is_ret(is_ret),
        .is_ld(is_ld), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2),
        .out_immx(out_immx), .out_branch_target(out_branch_target),
        .out_rd(out_rd), .out_opcode(out_opcode), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, op1, op2, immx, bt;
        logic [4:0]  rd;
        logic [5:0]  opc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_rf [32];
    bit          m_busy [32];
    bit          m_halted, m_valid;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
        m_halted = 1'b0;
        m_valid  = 1'b0;
        sb.delete();
    endtask

    task automatic set_idle();
        in_valid = 1'b0; in_pc = '0; in_inst = '0; is_st = 1'b0; is_ret = 1'b0;
        is_ld = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        out_ready = 1'b1;
    endtask

    // Reference model: predicts in_ready and the OF/EX contents from the stage's rules.
    task automatic eval();
        logic [4:0] rp1, rp2, rd;
        bit         b1, b2, hz, er, acc;
        exp_t       e;
        #1;
        rp1 = is_ret ? 5'd31 : in_inst[20:16];
        rp2 = is_st ? in_inst[25:21] : in_inst[15:11];
        rd  = in_inst[25:21];
        b1  = BYP && wb_en && (wb_addr == rp1);
        b2  = BYP && wb_en && (wb_addr == rp2);
        hz  = (m_busy[rp1] && !b1) || (m_busy[rp2] && !b2);
        er  = !flush && !m_halted && !hz && (!m_valid || out_ready);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_halted));
        check("in_ready", 32'(in_ready), 32'(er));
        acc = in_valid && er;
        if (acc) begin
            e.pc   = in_pc;
            e.op1  = b1 ? wb_data : m_rf[rp1];
            e.op2  = b2 ? wb_data : m_rf[rp2];
            e.immx = (in_inst[31:30] == 2'b10) ? {5'b0, in_inst[26:0]}
                                               : 32'($signed(in_inst[15:0]));
            e.bt   = in_pc + 32'($signed(in_inst[26:0]));
            e.rd   = rd;
            e.opc  = in_inst[31:26];
            sb.push_back(e);
        end
        if (flush && m_valid && !out_ready && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        m_valid = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : m_valid;
        if (wb_en) begin
            m_rf[wb_addr]   = wb_data;
            m_busy[wb_addr] = 1'b0;
        end
        if (acc && is_ld) m_busy[rd] = 1'b1;
        if (acc && in_inst[31:27] == 5'b11111) m_halted = 1'b1;
    endtask

    task automatic issue(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                         input bit ld, input bit st, input bit ret, input bit fl,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input bit ordy);
        @(negedge clk);
        in_valid = v; in_pc = pc; in_inst = inst; is_ld = ld; is_st = st;
        is_ret = ret; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
        out_ready = ordy;
        eval();
    endtask

    task automatic idle(input bit ordy);
        issue(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, ordy);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        set_idle();
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_op1", out_op1, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops an expected entry on every OF/EX handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_underflow: got out_pc %h with no expected entry", out_pc);
                end else begin
                    e = sb.pop_front();
                    check("mon_pc", out_pc, e.pc);
                    check("mon_op1", out_op1, e.op1);
                    check("mon_op2", out_op2, e.op2);
                    check("mon_immx", out_immx, e.immx);
                    check("mon_bt", out_branch_target, e.bt);
                    check("mon_rd", 32'(out_rd), 32'(e.rd));
                    check("mon_opc", 32'(out_opcode), 32'(e.opc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        set_idle();
        model_reset();
        reset_dut();

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            r[25:21] = 5'($urandom_range(0, 7));
            r[20:16] = 5'($urandom_range(0, 7));
            r[15:11] = 5'($urandom_range(0, 7));
            if (r[31:27] == 5'b11111) r[27] = 1'b0;
            issue($urandom_range(0, 3) != 0, $urandom, r, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                  5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0);
        end
        idle(1'b1);

        // Mid-run reset with a pending instruction and busy r5.
        reset_dut();
        issue(1, 32'h300, 32'h00A00000, 1, 0, 0, 0, 0, 5'd0, 32'h0, 0);
        idle(1'b0);
        check("t1_valid_pre", 32'(out_valid), 32'h1);
        reset_dut();
        issue(1, 32'h304, 32'h00050000, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1);
        idle(1'b1);
        check("t1_op1_zero", out_op1, 32'h0);

        // Load-use stall resolved by writeback.
        issue(1, 32'h200, 32'h00A00000, 1, 0, 0, 0, 0, 5'd0, 32'h0, 1);
        issue(1, 32'h204, 32'h00050000, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1);
        check("lu_stall", 32'(in_ready), 32'h0);
        issue(1, 32'h204, 32'h00050000, 0, 0, 0, 0, 1, 5'd5, 32'hDEAD, 1);
`ifndef OF_BYPASS_EN
        check("lu_wb_stall", 32'(in_ready), 32'h0);
        issue(1, 32'h204, 32'h00050000, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1);
`endif
        check("lu_accept", 32'(in_ready), 32'h1);
        idle(1'b1);
        check("lu_op1", out_op1, 32'hDEAD);

        // Backpressure: contents stable while EX stalls.
        issue(1, 32'h400, 32'h04000000, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0);
        for (int k = 0; k < 4; k++) begin
            issue(1, 32'h404, 32'h08000000, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0);
            check("bp_ready", 32'(in_ready), 32'h0);
            check("bp_pc", out_pc, 32'h400);
            check("bp_op1", out_op1, sb[0].op1);
        end
        issue(1, 32'h404, 32'h08000000, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1);
        check("bp_release", 32'(in_ready), 32'h1);
        idle(1'b1);

        // Immediate and branch target.
        issue(1, 32'h100, 32'h87FFFFFC, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1);
        idle(1'b1);
        check("br_target", out_branch_target, 32'h000000FC);
        check("br_immx", out_immx, 32'h07FFFFFC);
        issue(1, 32'h104, 32'h00008000, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1);
        idle(1'b1);
        check("imm_sext", out_immx, 32'hFFFF8000);

        // Return-address and store source ports.
        issue(0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 5'd31, 32'hA5A50031, 1);
        issue(0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 5'd3, 32'h00000303, 1);
        issue(1, 32'h500, 32'h00600000, 0, 1, 1, 0, 0, 5'd0, 32'h0, 1);
        idle(1'b1);
        check("ret_op1", out_op1, 32'hA5A50031);
        check("st_op2", out_op2, 32'h00000303);

        // Halt: blocked by flush, then latched until reset.
        issue(1, 32'h600, 32'hF8000000, 0, 0, 0, 1, 0, 5'd0, 32'h0, 1);
        idle(1'b1);
        check("halt_flushed", 32'(halted), 32'h0);
        issue(1, 32'h604, 32'hF8000000, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1);
        for (int k = 0; k < 3; k++) begin
            issue(1, 32'h608, 32'h00000000, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1);
            check("halt_set", 32'(halted), 32'h1);
            check("halt_ready", 32'(in_ready), 32'h0);
        end
        idle(1'b1);
        idle(1'b1);
        check("sb_drained", 32'(sb.size()), 32'h0);
        reset_dut();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
